palindrome_range_scanner: RTL and testbench



---
 rtl/analyzer_pkg.sv | 17 +
 rtl/is_palindrome.sv | 24 ++
 rtl/palindrome_range_scanner.sv | 166 ++++++++++++++++
 tb/tb_palindrome_range_scanner.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/analyzer_pkg.sv
// Shared definitions for the number-analyzer blocks.
//   W     : candidate width
//   CW    : counter width, one bit wider than W so a full 2^W range is countable
//   state_e : sequencer states used by palindrome_range_scanner
package analyzer_pkg;

  localparam int W  = 32;
  localparam int CW = W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage : analyzer_pkg

// File: rtl/is_palindrome.sv
// Combinational bit-palindrome checker.
// A value is a palindrome when bit i equals bit W-1-i for every i.
// Ports:
//   value_i : candidate word
//   pal_o   : 1 when value_i reads the same in both bit orders
module is_palindrome #(
  parameter int W = 32
) (
  input  logic [W-1:0] value_i,
  output logic         pal_o
);

  logic [W-1:0] rev;

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_rev
      assign rev[gi] = value_i[W-1-gi];
    end
  endgenerate

  assign pal_o = (rev == value_i);

endmodule : is_palindrome

// File: rtl/palindrome_range_scanner.sv
// Walks an inclusive range [lo, hi] through a single palindrome checker,
// one candidate per clock, counting palindromes and capturing the first.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   start_i       : request a scan (only looked at in IDLE)
//   abort_i       : stop a running scan (only looked at in SCAN/DRAIN)
//   lo_i, hi_i    : range bounds, captured when a start is accepted
//   busy_o        : high while in SCAN or DRAIN
//   done_o        : one-cycle pulse, scan finished normally
//   aborted_o     : one-cycle pulse, scan stopped by abort
//   err_o         : one-cycle pulse, start rejected (hi < lo)
//   pal_count_o   : palindromes counted so far / in range
//   found_any_o   : at least one palindrome seen
//   first_pal_o   : lowest palindrome seen, 0 if none
module palindrome_range_scanner
  import analyzer_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  input  logic          abort_i,
  input  logic [W-1:0]  lo_i,
  input  logic [W-1:0]  hi_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          aborted_o,
  output logic          err_o,
  output logic [CW-1:0] pal_count_o,
  output logic          found_any_o,
  output logic [W-1:0]  first_pal_o
);

  state_e        state_q;
  logic [W-1:0]  cand_q;
  logic [W-1:0]  cand_p_q;     // candidate that produced pal_q
  logic [W-1:0]  hi_q;
  logic          valid_q;
  logic          pal_q;
  logic          busy_q;
  logic          done_q;
  logic          aborted_q;
  logic          err_q;
  logic [CW-1:0] pal_count_q;
  logic          found_any_q;
  logic [W-1:0]  first_pal_q;

  logic          chk_pal;

  logic [CW-1:0] pal_count_d;
  logic          found_any_d;
  logic [W-1:0]  first_pal_d;

  is_palindrome #(.W(W)) u_chk (
    .value_i (cand_q),
    .pal_o   (chk_pal)
  );

  // Result accumulation for the verdict currently held in pal_q. Only used
  // on edges where the scan is not being aborted; an aborted edge discards
  // the in-flight verdict.
  always_comb begin
    pal_count_d = pal_count_q;
    found_any_d = found_any_q;
    first_pal_d = first_pal_q;
    if (valid_q && pal_q) begin
      pal_count_d = pal_count_q + CW'(1);
      if (!found_any_q) begin
        found_any_d = 1'b1;
        first_pal_d = cand_p_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cand_q      <= '0;
      cand_p_q    <= '0;
      hi_q        <= '0;
      valid_q     <= 1'b0;
      pal_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      err_q       <= 1'b0;
      pal_count_q <= '0;
      found_any_q <= 1'b0;
      first_pal_q <= '0;
    end else begin
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      err_q     <= 1'b0;

      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            if (hi_i >= lo_i) begin
              cand_q      <= lo_i;
              hi_q        <= hi_i;
              pal_count_q <= '0;
              found_any_q <= 1'b0;
              first_pal_q <= '0;
              busy_q      <= 1'b1;
              state_q     <= SCAN;
            end else begin
              err_q <= 1'b1;
            end
          end
        end

        SCAN: begin
          if (abort_i) begin
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            aborted_q <= 1'b1;
            state_q   <= IDLE;
          end else begin
            pal_count_q <= pal_count_d;
            found_any_q <= found_any_d;
            first_pal_q <= first_pal_d;
            pal_q       <= chk_pal;
            valid_q     <= 1'b1;
            cand_p_q    <= cand_q;
            // Stopping on equality (rather than incrementing past hi)
            // keeps cand from wrapping when hi is all ones.
            if (cand_q == hi_q) begin
              state_q <= DRAIN;
            end else begin
              cand_q <= cand_q + W'(1);
            end
          end
        end

        DRAIN: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          if (abort_i) begin
            aborted_q <= 1'b1;
            state_q   <= IDLE;
          end else begin
            pal_count_q <= pal_count_d;
            found_any_q <= found_any_d;
            first_pal_q <= first_pal_d;
            done_q      <= 1'b1;
            state_q     <= DONE;
          end
        end

        DONE: begin
          state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign aborted_o   = aborted_q;
  assign err_o       = err_q;
  assign pal_count_o = pal_count_q;
  assign found_any_o = found_any_q;
  assign first_pal_o = first_pal_q;

endmodule : palindrome_range_scanner

// File: tb/tb_palindrome_range_scanner.sv
module tb_palindrome_range_scanner;

  logic        clk;
  logic        rst_n;
  logic        start_i;
  logic        abort_i;
  logic [31:0] lo_i;
  logic [31:0] hi_i;
  logic        busy_o;
  logic        done_o;
  logic        aborted_o;
  logic        err_o;
  logic [32:0] pal_count_o;
  logic        found_any_o;
  logic [31:0] first_pal_o;

  palindrome_range_scanner dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .abort_i     (abort_i),
    .lo_i        (lo_i),
    .hi_i        (hi_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .aborted_o   (aborted_o),
    .err_o       (err_o),
    .pal_count_o (pal_count_o),
    .found_any_o (found_any_o),
    .first_pal_o (first_pal_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          kind;    // 0 done, 1 aborted, 2 err
    logic [32:0] count;
    logic        found;
    logic [31:0] first;
    int          lat;     // edge index of the pulse, start edge = 0
    int          busy;    // cycles busy_o is seen high
  } exp_t;

  exp_t        sb_q[$];
  int          total = 0;
  int          bad   = 0;
  logic [32:0] prev_count = '0;
  logic        prev_found = 1'b0;
  logic [31:0] prev_first = '0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit model_pal(input logic [31:0] v);
    for (int i = 0; i < 16; i++)
      if (v[i] != v[31-i]) return 1'b0;
    return 1'b1;
  endfunction

  // Scan [lo, hi]; abort_edge > 0 makes abort sampled at that edge;
  // mid_edge >= 0 raises a stray start after that edge.
  task automatic run_scan(input logic [31:0] lo, input logic [31:0] hi,
                          input int abort_edge, input int mid_edge);
    exp_t    e;
    longint  last;
    int      edge_n;
    int      busy_cnt;
    int      kind_got;
    e.count = '0; e.found = 1'b0; e.first = '0;
    if (hi < lo) begin
      e.kind = 2; e.count = prev_count; e.found = prev_found; e.first = prev_first;
      e.lat = 0; e.busy = 0;
    end else begin
      if (abort_edge > 0) begin
        e.kind = 1; e.lat = abort_edge; e.busy = abort_edge;
        last = longint'(lo) + abort_edge - 3;   // verdicts absorbed before the abort edge
      end else begin
        e.kind = 0;
        e.lat  = int'(longint'(hi) - longint'(lo) + 2);
        e.busy = e.lat;
        last = longint'(hi);
      end
      for (longint v = longint'(lo); v <= last; v++) begin
        if (model_pal(v[31:0])) begin
          if (!e.found) e.first = v[31:0];
          e.found = 1'b1;
          e.count = e.count + 33'd1;
        end
      end
    end
    sb_q.push_back(e);
    prev_count = e.count; prev_found = e.found; prev_first = e.first;

    @(posedge clk); #1;
    start_i = 1'b1; lo_i = lo; hi_i = hi;
    @(posedge clk); #1;
    start_i = 1'b0;
    edge_n = 0; busy_cnt = 0;
    while (edge_n < 300) begin
      if (busy_o) busy_cnt++;
      if (done_o || aborted_o || err_o) break;
      abort_i = (abort_edge > 0 && edge_n == abort_edge - 1);
      if (edge_n == mid_edge) begin
        start_i = 1'b1; lo_i = 32'd0; hi_i = 32'd7;
      end else begin
        start_i = 1'b0;
      end
      @(posedge clk); #1;
      edge_n++;
    end
    abort_i = 1'b0; start_i = 1'b0;
    e = sb_q.pop_front();
    if (edge_n >= 300) begin
      check_val("timeout", 64'd1, 64'd0);
    end else begin
      kind_got = done_o ? 0 : (aborted_o ? 1 : 2);
      $display("scan lo=%08h hi=%08h kind=%0d lat=%0d count=%0d first=%08h",
               lo, hi, kind_got, edge_n, pal_count_o, first_pal_o);
      check_val("kind", 64'(kind_got), 64'(e.kind));
      check_val("onehot", 64'(int'(done_o) + int'(aborted_o) + int'(err_o)), 64'd1);
      check_val("latency", 64'(edge_n), 64'(e.lat));
      check_val("busy_cycles", 64'(busy_cnt), 64'(e.busy));
      check_val("pal_count", 64'(pal_count_o), 64'(e.count));
      check_val("found_any", 64'(found_any_o), 64'(e.found));
      check_val("first_pal", 64'(first_pal_o), 64'(e.first));
      @(posedge clk); #1;
      check_val("pulse_gone", 64'({done_o, aborted_o, err_o, busy_o}), 64'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0; start_i = 1'b0; abort_i = 1'b0; lo_i = '0; hi_i = '0;
    #1;
    check_val("rst_async", 64'({busy_o, done_o, aborted_o, err_o, found_any_o}), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_count", 64'(pal_count_o), 64'd0);
    check_val("rst_first", 64'(first_pal_o), 64'd0);
    rst_n = 1'b1;

    run_scan(32'h0000_0000, 32'h0000_0000, 0, -1);
    run_scan(32'h0000_0001, 32'h0000_0008, 0, -1);
    run_scan(32'h8000_0000, 32'h8000_0002, 0, -1);
    run_scan(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, -1);
    run_scan(32'hA000_0000, 32'hA000_000F, 0, -1);
    run_scan(32'h8000_0001, 32'h8000_0010, 3, 1);
    run_scan(32'h0000_0005, 32'h0000_0004, 0, -1);
    for (int r = 0; r < 3; r++) begin
      logic [31:0] lo_r;
      lo_r = $urandom & 32'hFFFF_FF00;
      run_scan(lo_r, lo_r + 32'($urandom_range(0, 40)), 0, -1);
    end

    // Reset mid-scan must clear everything without waiting for an edge.
    @(posedge clk); #1;
    start_i = 1'b1; lo_i = 32'd0; hi_i = 32'd100;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    $display("reset mid-scan busy=%0b count=%0d", busy_o, pal_count_o);
    check_val("midrst_flags", 64'({busy_o, done_o, aborted_o, err_o, found_any_o}), 64'd0);
    check_val("midrst_count", 64'(pal_count_o), 64'd0);
    check_val("midrst_first", 64'(first_pal_o), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    prev_count = '0; prev_found = 1'b0; prev_first = '0;
    run_scan(32'h0000_0000, 32'h0000_0003, 0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_palindrome_range_scanner
